// File: rtl/toe_pkg.sv
// Shared constants and types for the TCP offload header extractor.
package toe_pkg;

   localparam logic [1:0]  RQ_NONE        = 2'd0;
   localparam logic [1:0]  RQ_LOOKUP      = 2'd1;
   localparam logic [1:0]  RQ_INSERT      = 2'd2;
   localparam logic [1:0]  RQ_DELETE      = 2'd3;
   localparam logic [7:0]  ERR_TIMEOUT    = 8'hFF;
   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  PROTO_TCP      = 8'd6;

   typedef enum logic [2:0] {
      StIdle,
      StParse,
      StReq,
      StWait,
      StDrain,
      StDrop
   } he_state_e;

   // SYN-only opens a flow, FIN closes it, everything else is a lookup.
   function automatic logic [1:0] rq_code(input logic syn, input logic ack, input logic fin);
      if (syn && !ack) return RQ_INSERT;
      if (fin)         return RQ_DELETE;
      return RQ_LOOKUP;
   endfunction

endpackage

// File: rtl/req_tracker.sv
// Tracks the outstanding searcher request: tag counter, timeout and completion matching.
module req_tracker
   import toe_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_wait,
   input  logic       i_done,
   input  logic [7:0] i_id,
   input  logic [7:0] i_error,
   output logic [7:0] o_id,
   output logic       o_finish,
   output logic       o_res_valid,
   output logic [7:0] o_res_id,
   output logic [7:0] o_res_error
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic [7:0]    r_id;
   logic [TW-1:0] r_tmo;
   logic          r_res_valid;
   logic [7:0]    r_res_id;
   logic [7:0]    r_res_error;
   logic          w_match;
   logic          w_expire;

   assign w_match  = i_wait & i_done & (i_id == r_id);
   assign w_expire = i_wait & (r_tmo == TW'(TIMEOUT - 1));
   assign o_finish = w_match | w_expire;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_id        <= 8'd0;
         r_tmo       <= '0;
         r_res_valid <= 1'b0;
         r_res_id    <= 8'd0;
         r_res_error <= 8'd0;
      end else begin
         r_res_valid <= 1'b0;
         if (i_start) begin
            r_tmo <= '0;
         end else if (i_wait && !o_finish) begin
            r_tmo <= r_tmo + 1'b1;
         end
         // Tag advances only once the request is retired so it stays stable through WAIT.
         if (o_finish) begin
            r_res_valid <= 1'b1;
            r_res_id    <= r_id;
            r_res_error <= w_match ? i_error : ERR_TIMEOUT;
            r_id        <= r_id + 8'd1;
         end
      end
   end

   assign o_id        = r_id;
   assign o_res_valid = r_res_valid;
   assign o_res_id    = r_res_id;
   assign o_res_error = r_res_error;

endmodule

// File: rtl/header_extractor.sv
// Parses Ethernet/IPv4/TCP headers from a byte stream and issues one search request per frame.
module header_extractor
   import toe_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        he_clk,
   input  logic        he_rst,
   input  logic [7:0]  he_in_data,
   input  logic        he_in_valid,
   input  logic        he_in_sop,
   input  logic        he_in_eop,
   output logic        he_in_ready,
   output logic [1:0]  he_rq,
   output logic [7:0]  he_id_out,
   output logic [31:0] he_ip_src,
   output logic [31:0] he_ip_dst,
   output logic [23:0] he_mac_src,
   output logic [23:0] he_mac_dst,
   output logic [15:0] he_port_src,
   output logic [15:0] he_port_dst,
   input  logic        he_done_in,
   input  logic [7:0]  he_id_in,
   input  logic [7:0]  he_error_in,
   output logic        he_res_valid,
   output logic [7:0]  he_res_id,
   output logic [7:0]  he_res_error,
   output logic [7:0]  he_drop_cnt
);

   he_state_e   r_state, w_state_nxt;
   logic [10:0] r_offset;
   logic [7:0]  r_etype_hi, r_flags, r_drop_cnt;
   logic [3:0]  r_ihl;
   logic        r_eop_seen;
   logic [31:0] r_ip_src, r_ip_dst;
   logic [23:0] r_mac_src, r_mac_dst;
   logic [15:0] r_port_src, r_port_dst;
   logic        w_accept, w_parse, w_is_flags, w_bad, w_drop_inc, w_finish;
   logic [10:0] w_off, w_t, w_flag_off;

   assign he_in_ready = !(r_state == StReq || r_state == StWait);
   assign w_accept    = he_in_valid & he_in_ready;
   assign w_off       = he_in_sop ? 11'd0 : r_offset;
   assign w_t         = 11'd14 + {5'd0, r_ihl, 2'b00};
   assign w_flag_off  = w_t + 11'd13;
   assign w_parse     = w_accept && (r_state == StParse) && !he_in_sop;
   // Earliest legal flags offset is 47 (IHL=5); guards against a stale IHL before byte 14.
   assign w_is_flags  = (w_off >= 11'd47) && (w_off == w_flag_off);
   assign w_bad = ((w_off == 11'd13) && ({r_etype_hi, he_in_data} != ETHERTYPE_IPV4))
               || ((w_off == 11'd14) && ((he_in_data[7:4] != 4'd4) || (he_in_data[3:0] < 4'd5)))
               || ((w_off == 11'd23) && (he_in_data != PROTO_TCP));

   always_comb begin
      w_state_nxt = r_state;
      w_drop_inc  = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_accept && he_in_sop) begin
               if (he_in_eop) w_drop_inc = 1'b1;
               else           w_state_nxt = StParse;
            end
         end
         StParse: begin
            if (w_accept && he_in_sop) begin
               w_drop_inc = 1'b1;
               if (he_in_eop) w_state_nxt = StIdle;
            end else if (w_parse && (w_bad || (he_in_eop && !w_is_flags))) begin
               if (he_in_eop) begin
                  w_drop_inc  = 1'b1;
                  w_state_nxt = StIdle;
               end else begin
                  w_state_nxt = StDrop;
               end
            end else if (w_parse && w_is_flags) begin
               w_state_nxt = StReq;
            end
         end
         StReq:  w_state_nxt = StWait;
         StWait: if (w_finish) w_state_nxt = StDrain;
         StDrain: begin
            if (w_accept && he_in_sop) begin
               if (!r_eop_seen) w_drop_inc = 1'b1;
               w_state_nxt = he_in_eop ? StIdle : StParse;
            end else if (r_eop_seen || (w_accept && he_in_eop)) begin
               w_state_nxt = StIdle;
            end
         end
         StDrop: begin
            if (w_accept && he_in_eop) begin
               w_drop_inc  = 1'b1;
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge he_clk) begin
      if (!he_rst) begin
         r_state    <= StIdle;
         r_offset   <= 11'd0;
         r_etype_hi <= 8'd0;
         r_flags    <= 8'd0;
         r_ihl      <= 4'd0;
         r_eop_seen <= 1'b0;
         r_drop_cnt <= 8'd0;
         r_ip_src   <= 32'd0;
         r_ip_dst   <= 32'd0;
         r_mac_src  <= 24'd0;
         r_mac_dst  <= 24'd0;
         r_port_src <= 16'd0;
         r_port_dst <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) r_offset <= (w_off == 11'd2047) ? 11'd2047 : w_off + 11'd1;
         if (w_accept && he_in_sop) r_ihl <= 4'd0;
         if (w_drop_inc && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
         if (r_state == StParse && w_state_nxt == StReq) r_eop_seen <= he_in_eop;
         if (w_parse) begin
            case (w_off)
               11'd3:  r_mac_dst[23:16] <= he_in_data;
               11'd4:  r_mac_dst[15:8]  <= he_in_data;
               11'd5:  r_mac_dst[7:0]   <= he_in_data;
               11'd9:  r_mac_src[23:16] <= he_in_data;
               11'd10: r_mac_src[15:8]  <= he_in_data;
               11'd11: r_mac_src[7:0]   <= he_in_data;
               11'd12: r_etype_hi       <= he_in_data;
               11'd14: r_ihl            <= he_in_data[3:0];
               11'd26: r_ip_src[31:24]  <= he_in_data;
               11'd27: r_ip_src[23:16]  <= he_in_data;
               11'd28: r_ip_src[15:8]   <= he_in_data;
               11'd29: r_ip_src[7:0]    <= he_in_data;
               11'd30: r_ip_dst[31:24]  <= he_in_data;
               11'd31: r_ip_dst[23:16]  <= he_in_data;
               11'd32: r_ip_dst[15:8]   <= he_in_data;
               11'd33: r_ip_dst[7:0]    <= he_in_data;
               default: ;
            endcase
            if (w_off >= 11'd34) begin
               if (w_off == w_t)          r_port_src[15:8] <= he_in_data;
               if (w_off == w_t + 11'd1)  r_port_src[7:0]  <= he_in_data;
               if (w_off == w_t + 11'd2)  r_port_dst[15:8] <= he_in_data;
               if (w_off == w_t + 11'd3)  r_port_dst[7:0]  <= he_in_data;
            end
            if (w_is_flags) r_flags <= he_in_data;
         end
      end
   end

   assign he_rq = (r_state == StReq) ? rq_code(r_flags[1], r_flags[4], r_flags[0]) : RQ_NONE;

   req_tracker #(
      .TIMEOUT (TIMEOUT)
   ) u_req_tracker (
      .i_clk       (he_clk),
      .i_rst_n     (he_rst),
      .i_start     (r_state == StReq),
      .i_wait      (r_state == StWait),
      .i_done      (he_done_in),
      .i_id        (he_id_in),
      .i_error     (he_error_in),
      .o_id        (he_id_out),
      .o_finish    (w_finish),
      .o_res_valid (he_res_valid),
      .o_res_id    (he_res_id),
      .o_res_error (he_res_error)
   );

   assign he_ip_src   = r_ip_src;
   assign he_ip_dst   = r_ip_dst;
   assign he_mac_src  = r_mac_src;
   assign he_mac_dst  = r_mac_dst;
   assign he_port_src = r_port_src;
   assign he_port_dst = r_port_dst;
   assign he_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_header_extractor.sv
// Directed bench for header_extractor: parse, request codes, drops, timeout, tag wrap, reset.
module tb_header_extractor;

   logic        he_clk = 1'b0;
   logic        he_rst = 1'b0;
   logic [7:0]  he_in_data = 8'd0;
   logic        he_in_valid = 1'b0, he_in_sop = 1'b0, he_in_eop = 1'b0;
   logic        he_in_ready;
   logic [1:0]  he_rq;
   logic [7:0]  he_id_out;
   logic [31:0] he_ip_src, he_ip_dst;
   logic [23:0] he_mac_src, he_mac_dst;
   logic [15:0] he_port_src, he_port_dst;
   logic        he_done_in = 1'b0;
   logic [7:0]  he_id_in = 8'd0, he_error_in = 8'd0;
   logic        he_res_valid;
   logic [7:0]  he_res_id, he_res_error, he_drop_cnt;

   int checks = 0;
   int errors = 0;
   logic [7:0] frm [128];
   int frm_len;
   bit saw_rq, saw_res;

   header_extractor #(.TIMEOUT(255)) dut (
      .he_clk(he_clk), .he_rst(he_rst), .he_in_data(he_in_data), .he_in_valid(he_in_valid),
      .he_in_sop(he_in_sop), .he_in_eop(he_in_eop), .he_in_ready(he_in_ready), .he_rq(he_rq),
      .he_id_out(he_id_out), .he_ip_src(he_ip_src), .he_ip_dst(he_ip_dst),
      .he_mac_src(he_mac_src), .he_mac_dst(he_mac_dst), .he_port_src(he_port_src),
      .he_port_dst(he_port_dst), .he_done_in(he_done_in), .he_id_in(he_id_in),
      .he_error_in(he_error_in), .he_res_valid(he_res_valid), .he_res_id(he_res_id),
      .he_res_error(he_res_error), .he_drop_cnt(he_drop_cnt)
   );

   always #5 he_clk = ~he_clk;

   always @(negedge he_clk) begin
      if (he_rq != 2'd0) saw_rq = 1'b1;
      if (he_res_valid)  saw_res = 1'b1;
   end

   task automatic build_frame(input logic [15:0] etype, input logic [7:0] ver_ihl,
                              input logic [7:0] proto, input logic [15:0] sp,
                              input logic [15:0] dp, input logic [7:0] flags, input int extra);
      int t;
      t = 14 + 4 * int'(ver_ihl[3:0]);
      for (int i = 0; i < 128; i++) frm[i] = 8'h00;
      for (int i = 0; i < 6; i++) begin
         frm[i]     = 8'hA0 + 8'(i);
         frm[6 + i] = 8'hB0 + 8'(i);
      end
      frm[12] = etype[15:8];   frm[13] = etype[7:0];
      frm[14] = ver_ihl;       frm[23] = proto;
      frm[26] = 8'hC0; frm[27] = 8'hA8; frm[28] = 8'h00; frm[29] = 8'h01;
      frm[30] = 8'h0A; frm[31] = 8'h00; frm[32] = 8'h00; frm[33] = 8'h02;
      frm[t]     = sp[15:8];  frm[t + 1] = sp[7:0];
      frm[t + 2] = dp[15:8];  frm[t + 3] = dp[7:0];
      frm[t + 13] = flags;
      for (int i = 0; i < extra; i++) frm[t + 14 + i] = 8'h5A;
      frm_len = t + 14 + extra;
   endtask

   // Called at a negedge; returns at the negedge after the last byte is accepted.
   task automatic send_range(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         int n;
         n = 0;
         he_in_data  = frm[i];
         he_in_sop   = (i == 0);
         he_in_eop   = (i == frm_len - 1);
         he_in_valid = 1'b1;
         while (!he_in_ready && n < 1000) begin
            @(negedge he_clk);
            n++;
         end
         if (n >= 1000) begin
            errors++;
            $display("FAIL ready_wait: byte %0d not accepted, ready=%b want 1", i, he_in_ready);
         end
         @(negedge he_clk);
         he_in_valid = 1'b0;
         he_in_sop   = 1'b0;
         he_in_eop   = 1'b0;
      end
   endtask

   task automatic do_done(input logic [7:0] id, input logic [7:0] err);
      he_done_in = 1'b1; he_id_in = id; he_error_in = err;
      @(negedge he_clk);
      he_done_in = 1'b0;
   endtask

   task automatic apply_reset();
      he_rst = 1'b0;
      he_in_valid = 1'b0; he_done_in = 1'b0;
      @(negedge he_clk);
      @(negedge he_clk);
      he_rst = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (he_in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", he_in_ready); end
      checks++; if (he_rq !== 2'd0) begin errors++; $display("FAIL rst_rq: got %0d want 0", he_rq); end
      checks++; if (he_id_out !== 8'd0) begin errors++; $display("FAIL rst_id: got %h want 00", he_id_out); end
      checks++; if (he_res_valid !== 1'b0 || he_res_id !== 8'd0 || he_res_error !== 8'd0) begin
         errors++; $display("FAIL rst_res: got %b/%h/%h want 0/00/00", he_res_valid, he_res_id, he_res_error); end
      checks++; if (he_drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_drop: got %h want 00", he_drop_cnt); end
      checks++; if ({he_ip_src, he_ip_dst, he_mac_src, he_mac_dst, he_port_src, he_port_dst} !== '0) begin
         errors++; $display("FAIL rst_fields: got %h/%h/%h want all 0", he_ip_src, he_mac_dst, he_port_src); end
   endtask

   task automatic test_syn_insert();
      build_frame(16'h0800, 8'h45, 8'd6, 16'h1234, 16'h0050, 8'h02, 0);
      send_range(0, frm_len - 1);
      checks++; if (he_rq !== 2'd2) begin errors++; $display("FAIL syn_rq: got %0d want 2", he_rq); end
      checks++; if (he_port_src !== 16'h1234 || he_port_dst !== 16'h0050) begin
         errors++; $display("FAIL syn_ports: got %h/%h want 1234/0050", he_port_src, he_port_dst); end
      checks++; if (he_ip_src !== 32'hC0A80001 || he_ip_dst !== 32'h0A000002) begin
         errors++; $display("FAIL syn_ip: got %h/%h want c0a80001/0a000002", he_ip_src, he_ip_dst); end
      checks++; if (he_mac_dst !== 24'hA3A4A5 || he_mac_src !== 24'hB3B4B5) begin
         errors++; $display("FAIL syn_mac: got %h/%h want a3a4a5/b3b4b5", he_mac_dst, he_mac_src); end
      checks++; if (he_id_out !== 8'd0) begin errors++; $display("FAIL syn_id: got %h want 00", he_id_out); end
      @(negedge he_clk);
      checks++; if (he_rq !== 2'd0 || he_in_ready !== 1'b0) begin
         errors++; $display("FAIL syn_wait: got rq=%0d ready=%b want 0/0", he_rq, he_in_ready); end
      do_done(8'd0, 8'd0);
      checks++; if (he_res_valid !== 1'b1 || he_res_error !== 8'd0 || he_res_id !== 8'd0) begin
         errors++; $display("FAIL syn_res: got %b/%h/%h want 1/00/00", he_res_valid, he_res_id, he_res_error); end
      @(negedge he_clk);
      checks++; if (he_res_valid !== 1'b0 || he_id_out !== 8'd1) begin
         errors++; $display("FAIL syn_after: got res=%b id=%h want 0/01", he_res_valid, he_id_out); end
   endtask

   task automatic test_ihl7_ack();
      build_frame(16'h0800, 8'h47, 8'd6, 16'hAAAA, 16'hBBBB, 8'h10, 2);
      send_range(0, 55);
      checks++; if (he_rq !== 2'd1) begin errors++; $display("FAIL ihl7_rq: got %0d want 1", he_rq); end
      checks++; if (he_port_src !== 16'hAAAA || he_port_dst !== 16'hBBBB) begin
         errors++; $display("FAIL ihl7_ports: got %h/%h want aaaa/bbbb", he_port_src, he_port_dst); end
      @(negedge he_clk);
      do_done(8'd1, 8'h33);
      checks++; if (he_res_valid !== 1'b1 || he_res_id !== 8'd1 || he_res_error !== 8'h33) begin
         errors++; $display("FAIL ihl7_res: got %b/%h/%h want 1/01/33", he_res_valid, he_res_id, he_res_error); end
      send_range(56, 57);
      checks++; if (he_id_out !== 8'd2 || he_in_ready !== 1'b1) begin
         errors++; $display("FAIL ihl7_end: got id=%h ready=%b want 02/1", he_id_out, he_in_ready); end
   endtask

   task automatic test_drops();
      saw_rq = 1'b0;
      build_frame(16'h0806, 8'h45, 8'd6, 16'h1111, 16'h2222, 8'h02, 10);
      send_range(0, frm_len - 1);
      repeat (3) @(negedge he_clk);
      checks++; if (saw_rq !== 1'b0 || he_drop_cnt !== 8'd1) begin
         errors++; $display("FAIL arp_drop: got rq_seen=%b cnt=%h want 0/01", saw_rq, he_drop_cnt); end
      build_frame(16'h0800, 8'h44, 8'd6, 16'h1111, 16'h2222, 8'h02, 10);
      send_range(0, frm_len - 1);
      @(negedge he_clk);
      checks++; if (saw_rq !== 1'b0 || he_drop_cnt !== 8'd2) begin
         errors++; $display("FAIL ihl4_drop: got rq_seen=%b cnt=%h want 0/02", saw_rq, he_drop_cnt); end
      build_frame(16'h0800, 8'h45, 8'd17, 16'h1111, 16'h2222, 8'h02, 0);
      send_range(0, frm_len - 1);
      @(negedge he_clk);
      checks++; if (saw_rq !== 1'b0 || he_drop_cnt !== 8'd3) begin
         errors++; $display("FAIL udp_drop: got rq_seen=%b cnt=%h want 0/03", saw_rq, he_drop_cnt); end
      build_frame(16'h0800, 8'h45, 8'd6, 16'h1111, 16'h2222, 8'h02, 0);
      frm_len = 40;
      send_range(0, 39);
      @(negedge he_clk);
      checks++; if (saw_rq !== 1'b0 || he_drop_cnt !== 8'd4) begin
         errors++; $display("FAIL short_drop: got rq_seen=%b cnt=%h want 0/04", saw_rq, he_drop_cnt); end
   endtask

   task automatic test_sop_abort();
      build_frame(16'h0800, 8'h45, 8'd6, 16'h4321, 16'h0016, 8'h11, 0);
      send_range(0, 19);
      send_range(0, frm_len - 1);
      checks++; if (he_rq !== 2'd3 || he_port_src !== 16'h4321) begin
         errors++; $display("FAIL abort_rq: got rq=%0d sp=%h want 3/4321", he_rq, he_port_src); end
      checks++; if (he_drop_cnt !== 8'd5 || he_id_out !== 8'd2) begin
         errors++; $display("FAIL abort_cnt: got cnt=%h id=%h want 05/02", he_drop_cnt, he_id_out); end
      @(negedge he_clk);
      do_done(8'd2, 8'd0);
      @(negedge he_clk);
   endtask

   task automatic test_timeout();
      int n;
      apply_reset();
      build_frame(16'h0800, 8'h45, 8'd6, 16'h1000, 16'h2000, 8'h18, 0);
      send_range(0, frm_len - 1);
      checks++; if (he_rq !== 2'd1) begin errors++; $display("FAIL tmo_rq: got %0d want 1", he_rq); end
      @(negedge he_clk);
      n = 0;
      while (!he_res_valid && n < 400) begin
         he_done_in = (n == 10); he_id_in = 8'h05; he_error_in = 8'h11;
         @(negedge he_clk);
         n++;
      end
      he_done_in = 1'b0;
      checks++; if (n !== 255) begin errors++; $display("FAIL tmo_len: got %0d want 255", n); end
      checks++; if (he_res_error !== 8'hFF || he_res_id !== 8'd0 || he_id_out !== 8'd1) begin
         errors++; $display("FAIL tmo_res: got %h/%h id=%h want ff/00/01", he_res_error, he_res_id, he_id_out); end
      @(negedge he_clk);
   endtask

   task automatic test_back_to_back();
      logic [7:0] fl;
      logic [1:0] code;
      apply_reset();
      for (int i = 0; i < 256; i++) begin
         case (i % 3)
            0:       begin fl = 8'h02; code = 2'd2; end
            1:       begin fl = 8'h10; code = 2'd1; end
            default: begin fl = 8'h11; code = 2'd3; end
         endcase
         build_frame(16'h0800, 8'h45, 8'd6, 16'(i), 16'h0050, fl, 0);
         send_range(0, frm_len - 1);
         checks++; if (he_id_out !== 8'(i) || he_rq !== code) begin
            errors++; $display("FAIL b2b_%0d: got id=%h rq=%0d want %h/%0d", i, he_id_out, he_rq, 8'(i), code); end
         @(negedge he_clk);
         do_done(8'(i), 8'd0);
      end
      @(negedge he_clk);
      checks++; if (he_id_out !== 8'd0 || he_drop_cnt !== 8'd0) begin
         errors++; $display("FAIL b2b_wrap: got id=%h cnt=%h want 00/00", he_id_out, he_drop_cnt); end
   endtask

   task automatic test_reset_in_wait();
      build_frame(16'h0800, 8'h45, 8'd6, 16'h0001, 16'h0002, 8'h10, 0);
      send_range(0, frm_len - 1);
      @(negedge he_clk);
      do_done(8'd0, 8'd0);
      @(negedge he_clk);
      send_range(0, frm_len - 1);
      checks++; if (he_id_out !== 8'd1) begin errors++; $display("FAIL rw_pre_id: got %h want 01", he_id_out); end
      @(negedge he_clk);
      saw_res = 1'b0;
      he_rst = 1'b0;
      @(negedge he_clk);
      he_rst = 1'b1;
      do_done(8'd1, 8'h22);
      do_done(8'd0, 8'h22);
      repeat (3) @(negedge he_clk);
      checks++; if (saw_res !== 1'b0 || he_id_out !== 8'd0) begin
         errors++; $display("FAIL rw_late_done: got res_seen=%b id=%h want 0/00", saw_res, he_id_out); end
      checks++; if (he_in_ready !== 1'b1 || he_rq !== 2'd0) begin
         errors++; $display("FAIL rw_idle: got ready=%b rq=%0d want 1/0", he_in_ready, he_rq); end
   endtask

   initial begin
      @(negedge he_clk);
      test_reset();
      test_syn_insert();
      test_ihl7_ack();
      test_drops();
      test_sop_abort();
      test_timeout();
      test_back_to_back();
      test_reset_in_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
